// File: rtl/cnn_fc_feed_ctrl.sv
// Feeds one pooled frame from the layer-2 output FIFO into the FC layer.
// Optional statistics counters are enabled with `define CNN_FC_FEED_STATS_EN.
module cnn_fc_feed_ctrl #(
    parameter int DW         = 16,
    parameter int FRAME_LEN  = 256,
    parameter int FILL_LEVEL = 245,
    parameter int CW         = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [CW-1:0] fifo_rdusedw,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic          fifo_we,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_re,
    input  logic          fc_ready,
    output logic [DW-1:0] fc_data,
    output logic          fc_valid,
    output logic          fc_first,
    output logic          fc_last,
    input  logic          fc_done,
    output logic          frame_done,
    output logic          busy,
`ifdef CNN_FC_FEED_STATS_EN
    output logic [15:0]   frame_cnt,
    output logic [15:0]   stall_cnt,
`endif
    output logic          err_ovf,
    input  logic          clr_err
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, WAIT_FC} state_t;

    localparam logic [CW-1:0] LEN_C   = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST_C  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] LEVEL_C = CW'(FILL_LEVEL);

    state_t        state_q, state_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic          fc_valid_q, fc_valid_d;
    logic          fc_first_q, fc_first_d;
    logic          fc_last_q, fc_last_d;
    logic          frame_done_q, frame_done_d;
    logic          err_ovf_q, err_ovf_d;

    // Read data comes straight from the FIFO; only the qualifiers are registered.
    assign fifo_re    = (state_q == STREAM) & fc_ready & ~fifo_empty & (rd_cnt_q < LEN_C);
    assign fc_data    = fifo_dout;
    assign fc_valid   = fc_valid_q;
    assign fc_first   = fc_first_q;
    assign fc_last    = fc_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign err_ovf    = err_ovf_q;

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        if (fifo_re) rd_cnt_d = rd_cnt_q + CW'(1);
        case (state_q)
            IDLE:    if (enable) state_d = FILL;
            FILL:    if (fifo_rdusedw >= LEVEL_C) state_d = STREAM;
            STREAM:  if (fifo_re && rd_cnt_q == LAST_C) state_d = WAIT_FC;
            WAIT_FC: if (fc_done) state_d = enable ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == FILL && state_q != FILL) rd_cnt_d = '0;

        fc_valid_d   = fifo_re;
        fc_first_d   = fifo_re & (rd_cnt_q == '0);
        fc_last_d    = fifo_re & (rd_cnt_q == LAST_C);
        frame_done_d = fifo_re & (rd_cnt_q == LAST_C);
        // A new overflow wins over a simultaneous clear.
        err_ovf_d    = (fifo_we & fifo_full & ~fifo_re) | (err_ovf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_cnt_q     <= '0;
            fc_valid_q   <= 1'b0;
            fc_first_q   <= 1'b0;
            fc_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            fc_valid_q   <= fc_valid_d;
            fc_first_q   <= fc_first_d;
            fc_last_q    <= fc_last_d;
            frame_done_q <= frame_done_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

`ifdef CNN_FC_FEED_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q + {15'd0, frame_done_q};
        stall_cnt_d = stall_cnt_q;
        if (state_q == IDLE && state_d == FILL)
            stall_cnt_d = '0;
        else if (state_q == STREAM && fc_ready && fifo_empty && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_fc_feed_ctrl.sv
// Directed bench for cnn_fc_feed_ctrl with a behavioural FIFO and an output monitor.
module tb_cnn_fc_feed_ctrl;
    localparam int DW = 16, FL = 256, CW = 10, DEPTH = 512;

    logic          clk = 1'b0, rst = 1'b0;
    logic          enable = 0, fc_ready = 0, fc_done = 0, clr_err = 0;
    logic          force_full = 0, ovf_we = 0, wr_req = 0;
    logic [DW-1:0] wr_data = '0, wr_next = '0, dout;
    logic [CW-1:0] fifo_rdusedw;
    logic          fifo_empty, fifo_full, fifo_we, fifo_re;
    logic [DW-1:0] fc_data;
    logic          fc_valid, fc_first, fc_last, frame_done, busy, err_ovf;
`ifdef CNN_FC_FEED_STATS_EN
    logic [15:0]   frame_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    cnn_fc_feed_ctrl #(.DW(DW), .FRAME_LEN(FL), .FILL_LEVEL(245), .CW(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_rdusedw(fifo_rdusedw),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_we(fifo_we),
        .fifo_dout(dout), .fifo_re(fifo_re), .fc_ready(fc_ready), .fc_data(fc_data),
        .fc_valid(fc_valid), .fc_first(fc_first), .fc_last(fc_last), .fc_done(fc_done),
        .frame_done(frame_done), .busy(busy),
`ifdef CNN_FC_FEED_STATS_EN
        .frame_cnt(frame_cnt), .stall_cnt(stall_cnt),
`endif
        .err_ovf(err_ovf), .clr_err(clr_err));

    // FIFO model: show-ahead-free, data valid the cycle after a read.
    logic [DW-1:0] mem [0:1023];
    int wr_ptr = 0, rd_ptr = 0, cnt;
    bit underflow = 0;
    assign cnt          = wr_ptr - rd_ptr;
    assign fifo_rdusedw = cnt[CW-1:0];
    assign fifo_empty   = (cnt == 0);
    assign fifo_full    = (cnt >= DEPTH) | force_full;
    assign fifo_we      = wr_req | ovf_we;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 0; rd_ptr <= 0; dout <= '0;
        end else begin
            if (wr_req && !fifo_full) begin
                mem[wr_ptr % 1024] <= wr_data;
                wr_ptr <= wr_ptr + 1;
            end
            if (fifo_re) begin
                if (cnt == 0) underflow <= 1'b1;
                else begin
                    dout   <= mem[rd_ptr % 1024];
                    rd_ptr <= rd_ptr + 1;
                end
            end
        end
    end

    // Writer: wr_left words, one every wr_gap+1 cycles.
    int wr_left = 0, wr_gap = 0, gap_cnt = 0;
    always @(negedge clk) begin
        if (wr_left > 0 && gap_cnt == 0) begin
            wr_req = 1'b1; wr_data = wr_next; wr_next = wr_next + 1'b1;
            wr_left = wr_left - 1; gap_cnt = wr_gap;
        end else begin
            wr_req = 1'b0;
            if (gap_cnt > 0) gap_cnt = gap_cnt - 1;
        end
    end

    // Monitor
    logic [DW-1:0] rx_data [0:1023];
    bit rx_first [0:1023], rx_last [0:1023];
    int rx_n = 0, re_n = 0, done_n = 0, misalign = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_re) re_n++;
            if (fc_valid) begin
                if (rx_n < 1024) begin
                    rx_data[rx_n] = fc_data; rx_first[rx_n] = fc_first; rx_last[rx_n] = fc_last;
                end
                rx_n++;
            end
            if (frame_done) done_n++;
            if (frame_done !== (fc_valid & fc_last) || ((fc_first | fc_last) & ~fc_valid)) misalign++;
        end
    end

    int n_checks = 0, n_fails = 0;

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic clear_mon();
        rx_n = 0; re_n = 0; done_n = 0; misalign = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string nm);
        int k = 0;
        while (rx_n < n && k < budget) begin tick(1); k++; end
        n_checks++;
        if (rx_n < n) begin $display("FAIL %s timeout: rx=%0d need=%0d", nm, rx_n, n); n_fails++; end
    endtask

    function automatic int seq_errs(input int n, input logic [DW-1:0] base);
        int e = 0;
        logic [DW-1:0] exp_d;
        for (int i = 0; i < n; i++) begin
            exp_d = base + DW'(i);
            if (rx_data[i] !== exp_d || rx_first[i] !== (i % FL == 0) || rx_last[i] !== (i % FL == FL - 1)) e++;
        end
        return e;
    endfunction

    task automatic finish_frame(input string nm);
        enable = 0; fc_done = 1; tick(1); fc_done = 0;
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL %s_idle: busy=%0b want 0", nm, busy); n_fails++; end
    endtask

    task automatic test_reset();
        #2 rst = 1; enable = 1; fc_ready = 1;
        tick(2);
        n_checks++;
        if ({fc_valid, fc_first, fc_last, frame_done, busy, err_ovf, fifo_re} !== 7'b0) begin
            $display("FAIL reset_outs: got %b want 0000000",
                     {fc_valid, fc_first, fc_last, frame_done, busy, err_ovf, fifo_re}); n_fails++;
        end
        enable = 0; rst = 0; tick(3);
        n_checks++;
        if (busy !== 1'b0) begin $display("FAIL idle_hold: busy=%0b want 0", busy); n_fails++; end
    endtask

    task automatic test_basic_frame();
        int e;
        clear_mon(); wr_next = 16'h0000; wr_gap = 0; enable = 1; fc_ready = 1;
        wr_left = 244; tick(250);
        n_checks++;
        if (re_n !== 0 || busy !== 1'b1) begin
            $display("FAIL basic_fill_wait: reads=%0d busy=%0b want 0 1", re_n, busy); n_fails++;
        end
        wr_left = 12;
        wait_rx(256, 400, "basic");
        tick(5);
        e = seq_errs(256, 16'h0000);
        n_checks++;
        if (rx_n !== 256 || e !== 0) begin $display("FAIL basic_seq: words=%0d bad=%0d want 256 0", rx_n, e); n_fails++; end
        n_checks++;
        if (done_n !== 1 || misalign !== 0) begin
            $display("FAIL basic_done: pulses=%0d misaligned=%0d want 1 0", done_n, misalign); n_fails++;
        end
        n_checks++;
        if (busy !== 1'b1 || underflow) begin $display("FAIL basic_wait_fc: busy=%0b uf=%0b want 1 0", busy, underflow); n_fails++; end
        finish_frame("basic");
    endtask

    task automatic test_backpressure();
        int n0, e;
        clear_mon(); wr_next = 16'h1000; enable = 1; fc_ready = 1; wr_left = 256;
        wait_rx(100, 600, "bp_reach");
        fc_ready = 0; n0 = rx_n; tick(5);
        n_checks++;
        if (rx_n - n0 > 1) begin $display("FAIL bp_inflight: delivered=%0d want <=1", rx_n - n0); n_fails++; end
        fc_ready = 1;
        wait_rx(256, 400, "bp");
        tick(5);
        e = seq_errs(256, 16'h1000);
        n_checks++;
        if (rx_n !== 256 || e !== 0 || done_n !== 1) begin
            $display("FAIL bp_seq: words=%0d bad=%0d pulses=%0d want 256 0 1", rx_n, e, done_n); n_fails++;
        end
        finish_frame("bp");
    endtask

    task automatic test_underrun();
        int e;
        clear_mon(); wr_next = 16'h2000; enable = 1; wr_gap = 0; wr_left = 245;
        tick(250);
        wr_gap = 2; wr_left = 11;
        wait_rx(256, 500, "underrun");
        tick(3);
        e = seq_errs(256, 16'h2000);
        n_checks++;
        if (rx_n !== 256 || e !== 0 || underflow) begin
            $display("FAIL underrun_seq: words=%0d bad=%0d uf=%0b want 256 0 0", rx_n, e, underflow); n_fails++;
        end
        n_checks++;
        if (done_n !== 1 || misalign !== 0) begin
            $display("FAIL underrun_done: pulses=%0d misaligned=%0d want 1 0", done_n, misalign); n_fails++;
        end
        wr_gap = 0;
        finish_frame("underrun");
    endtask

    task automatic test_chaining();
        int k, e;
        clear_mon(); wr_next = 16'h3000; enable = 1; wr_gap = 0; wr_left = 768;
        wait_rx(50, 600, "chain_early");
        fc_done = 1; tick(1); fc_done = 0;
        k = 0;
        while (!(re_n == 256 && fifo_re) && k < 400) begin tick(1); k++; end
        fc_done = 1; tick(1); fc_done = 0;
        tick(9);
        n_checks++;
        if (rx_n !== 256 || re_n !== 256 || busy !== 1'b1) begin
            $display("FAIL chain_ignore_done: words=%0d reads=%0d busy=%0b want 256 256 1", rx_n, re_n, busy); n_fails++;
        end
        fc_done = 1; tick(1); fc_done = 0;
        for (int f = 1; f < 3; f++) begin
            k = 0;
            while (done_n < f + 1 && k < 600) begin tick(1); k++; end
            tick(10);
            n_checks++;
            if (rx_n !== 256 * (f + 1)) begin $display("FAIL chain_frame%0d: words=%0d want %0d", f, rx_n, 256 * (f + 1)); n_fails++; end
            if (f < 2) begin fc_done = 1; tick(1); fc_done = 0; end
        end
        e = seq_errs(768, 16'h3000);
        n_checks++;
        if (e !== 0 || done_n !== 3 || misalign !== 0 || underflow) begin
            $display("FAIL chain_seq: bad=%0d pulses=%0d misaligned=%0d want 0 3 0", e, done_n, misalign); n_fails++;
        end
        finish_frame("chain");
    endtask

    task automatic test_overflow_reset();
        int e;
        clear_mon(); enable = 1; tick(2);
        n_checks++;
        if (err_ovf !== 1'b0) begin $display("FAIL ovf_pre: err=%0b want 0", err_ovf); n_fails++; end
        force_full = 1; ovf_we = 1; tick(1); force_full = 0; ovf_we = 0; tick(4);
        n_checks++;
        if (err_ovf !== 1'b1) begin $display("FAIL ovf_set_hold: err=%0b want 1", err_ovf); n_fails++; end
        clr_err = 1; tick(1); clr_err = 0;
        n_checks++;
        if (err_ovf !== 1'b0) begin $display("FAIL ovf_clear: err=%0b want 0", err_ovf); n_fails++; end
        force_full = 1; ovf_we = 1; clr_err = 1; tick(1); force_full = 0; ovf_we = 0; clr_err = 0;
        n_checks++;
        if (err_ovf !== 1'b1 || busy !== 1'b1 || re_n !== 0) begin
            $display("FAIL ovf_priority: err=%0b busy=%0b reads=%0d want 1 1 0", err_ovf, busy, re_n); n_fails++;
        end
        wr_next = 16'h4000; wr_left = 256;
        wait_rx(50, 600, "rst_reach");
        rst = 1; wr_left = 0; #1;
        n_checks++;
        if ({fc_valid, fc_first, fc_last, frame_done, busy, err_ovf, fifo_re} !== 7'b0) begin
            $display("FAIL rst_mid: got %b want 0000000",
                     {fc_valid, fc_first, fc_last, frame_done, busy, err_ovf, fifo_re}); n_fails++;
        end
        tick(2); clear_mon(); rst = 0;
        wr_next = 16'h5000; wr_left = 256;
        wait_rx(256, 600, "post_rst");
        tick(3);
        e = seq_errs(256, 16'h5000);
        n_checks++;
        if (rx_n !== 256 || e !== 0 || done_n !== 1) begin
            $display("FAIL post_rst_seq: words=%0d bad=%0d pulses=%0d want 256 0 1", rx_n, e, done_n); n_fails++;
        end
        finish_frame("post_rst");
    endtask

    task automatic test_stats();
        int k, e;
        clear_mon(); wr_next = 16'h6000; enable = 1; wr_gap = 0; wr_left = 245;
        k = 0;
        while (!(re_n == 245 && fifo_empty) && k < 600) begin tick(1); k++; end
        tick(5);
        wr_left = 11;
        wait_rx(256, 200, "stall_frame");
        tick(3);
        e = seq_errs(256, 16'h6000);
        n_checks++;
        if (rx_n !== 256 || e !== 0 || underflow) begin
            $display("FAIL stall_seq: words=%0d bad=%0d uf=%0b want 256 0 0", rx_n, e, underflow); n_fails++;
        end
`ifdef CNN_FC_FEED_STATS_EN
        n_checks++;
        if (frame_cnt !== 16'd2) begin $display("FAIL frame_cnt: got %0d want 2", frame_cnt); n_fails++; end
        n_checks++;
        if (stall_cnt !== 16'd7) begin $display("FAIL stall_cnt: got %0d want 7", stall_cnt); n_fails++; end
`endif
        finish_frame("stall");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_underrun();
        test_chaining();
        test_overflow_reset();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/cnn_fc_feed_ctrl.md
Name: cnn_fc_feed_ctrl

Overview:
- Sequences the transfer of one pooled feature frame (FRAME_LEN words) from the layer-2 output FIFO into the fully-connected (FC) layer.
- Owns the FIFO read enable and waits until enough data has been buffered before starting.
- Meters reads against FC back-pressure, tags the first and last word of each frame, and waits for the FC layer to finish before starting the next frame.
- Replaces free-running read counters with an explicit FSM that has a defined frame boundary.

Parameters:
- DW, 16: data word width.
- FRAME_LEN, 256: words per frame.
- FILL_LEVEL, 245: FIFO occupancy required before streaming starts; legal range 1..FRAME_LEN.
- CW, 10: width of the occupancy and counter fields; must satisfy 2^CW > FRAME_LEN.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits leaving IDLE.
- fifo_rdusedw  in  CW  FIFO words available for read.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- fifo_we  in  1  FIFO write strobe (monitored only).
- fifo_dout  in  DW  FIFO read data; valid the cycle after fifo_re.
- fifo_re  out  1  FIFO read enable, combinational.
- fc_ready  in  1  FC can accept a word in the next cycle.
- fc_data  out  DW  word to FC; equals fifo_dout.
- fc_valid  out  1  fc_data valid, registered.
- fc_first  out  1  qualifies the first word of a frame.
- fc_last  out  1  qualifies the last word of a frame.
- fc_done  in  1  pulse: FC finished computing on the frame.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- busy  out  1  high in any state except IDLE.
- err_ovf  out  1  sticky overflow error flag.
- clr_err  in  1  clears err_ovf.

Behaviour:
- Reset values: fc_valid=0, fc_first=0, fc_last=0, frame_done=0, busy=0, err_ovf=0, rd_cnt=0, state=IDLE. fifo_re=0 while rst is high.
- States:
  - IDLE: go to FILL when enable=1.
  - FILL: go to STREAM when fifo_rdusedw >= FILL_LEVEL.
  - STREAM: issue reads (rules below). When a read is issued with rd_cnt==FRAME_LEN-1, go to WAIT_FC.
  - WAIT_FC: on fc_done go to IDLE if enable=0, otherwise go to FILL.
- Read issue rule: fifo_re = (state==STREAM) & fc_ready & ~fifo_empty & (rd_cnt < FRAME_LEN). At most one read per cycle, giving full throughput when there are no stalls.
- rd_cnt increments on each fifo_re and clears on entry to FILL.
- Latency: fifo_re in cycle t → in cycle t+1, fc_valid=1 and fc_data=fifo_dout.
  - fc_first=1 with the word read when rd_cnt==0.
  - fc_last=1 with the word read when rd_cnt==FRAME_LEN-1.
  - frame_done pulses in the same cycle as fc_last.
- The FC layer accepts every fc_valid word unconditionally. fc_ready is sampled only at read issue, so a deassertion stops reads from the next cycle; the one word already in flight is still delivered.
- FIFO empty mid-frame: reads stall and the state stays STREAM; no word is dropped or duplicated.
- fc_done in any state other than WAIT_FC is ignored.
- fc_done in the same cycle as the WAIT_FC entry transition is not seen; it must arrive later.
- enable=0 during FILL, STREAM or WAIT_FC: the current frame completes first. enable is re-examined only in WAIT_FC.
- Overflow:
  - err_ovf sets when fifo_we & fifo_full & ~fifo_re.
  - Set has priority over clr_err in the same cycle.
  - err_ovf does not alter sequencing.
- Asynchronous rst mid-frame: outputs return to reset values immediately. The FIFO is reset externally; the controller does not flush it.

Optional Feature:
- Macro: CNN_FC_FEED_STATS_EN.
- When defined, adds two outputs:
  - frame_cnt [15:0]: increments on frame_done, wraps 0xFFFF→0.
  - stall_cnt [15:0]: increments each STREAM cycle with fc_ready=1 & fifo_empty=1, saturates at 0xFFFF, clears on IDLE→FILL.
  - Both reset to 0.
- When not defined, neither port nor register exists, and all other behaviour is identical.

Test Plan:
- Basic frame: write 256 words 0..255 back-to-back, fc_ready=1, enable=1 → STREAM entered once rdusedw reaches 245; fc_valid high for exactly 256 words in order 0..255; fc_first on word 0; fc_last and frame_done on word 255; busy stays high until fc_done.
- Back-pressure: hold fc_ready=0 for 5 cycles starting at word 100 → at most 1 word delivered after the drop, no gaps in data, count still 256.
- Underrun: write at 1 word per 3 cycles after FILL_LEVEL is reached → STREAM stalls on empty; delivered sequence intact; fc_last lands on word 255.
- Frame chaining: 3 frames of 256 words, fc_done pulsed 10 cycles after each fc_last, enable held at 1 → 768 words delivered, 3 frame_done pulses, FILL re-entered before each frame; an early fc_done during STREAM is ignored.
- Overflow and reset: assert fifo_we with fifo_full=1 in FILL → err_ovf=1 and held; clr_err clears it. Assert rst at word 50 → all outputs go to 0 and the next frame starts with fc_first.
- With CNN_FC_FEED_STATS_EN defined: after 2 frames frame_cnt=2; a forced 7-cycle empty stall with fc_ready=1 gives stall_cnt=7.
